sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares the single SRAM-like bus of the MIPS core between the instruction-fetch and data-access ports of the datapath.
- Serialises transactions, with exactly one outstanding transaction at a time.
- Forwards handshakes and read data back to the master that owns the current transaction.
- Sits between the datapath and the memory/cache bridge.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
inst_req  input  1  instruction master request
inst_addr  input  ADDR_W  instruction fetch address
inst_addr_ok  output  1  address accepted, to instruction master
inst_data_ok  output  1  read data valid, to instruction master
inst_rdata  output  DATA_W  fetched instruction
data_req  input  1  data master request
data_wr  input  1  1=write, 0=read
data_size  input  2  0=byte, 1=half, 2=word
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  write data
data_addr_ok  output  1  address accepted, to data master
data_data_ok  output  1  transaction complete / read data valid, to data master
data_rdata  output  DATA_W  load data
req  output  1  bus request to slave
wr  output  1  bus write enable
size  output  2  bus transfer size
addr  output  ADDR_W  bus address
wdata  output  DATA_W  bus write data
addr_ok  input  1  slave accepted address
data_ok  input  1  slave data phase complete
rdata  input  DATA_W  slave read data

Behaviour:
- State machine has three states: IDLE, ADDR, DATA. A registered owner bit records the current master: 0=inst, 1=data. A registered last_grant bit drives round-robin.
- Reset: state=IDLE, owner=0, last_grant=0. Outputs req, wr, size, addr, wdata, inst_addr_ok, inst_data_ok, data_addr_ok and data_data_ok are all 0.
- IDLE, grant decision:
  - Only data_req=1: owner=1.
  - Only inst_req=1: owner=0.
  - Both =1: owner = ~last_grant. After reset this favours the data master, since last_grant=0 gives owner=1.
  - On any grant: last_grant<=owner, go to ADDR.
  - No requests: stay in IDLE.
  - req=0 in IDLE, so the earliest bus req is 1 cycle after the master raises its request.
- ADDR:
  - req=1.
  - addr, wr, size and wdata are driven combinationally from the owner's live inputs.
  - Instruction owner: wr=0, size=2, wdata=0.
  - The master holds its request fields stable until it sees addr_ok; this is SRAM-like protocol.
  - Slave addr_ok=1: pulse the owner's *_addr_ok in the same cycle, then go to DATA.
  - addr_ok and data_ok both 1 in the same cycle: pulse both of the owner's *_addr_ok and *_data_ok, then go to IDLE.
  - Owner drops its req before addr_ok (protocol violation, abort): go to IDLE, req=0 next cycle, nothing forwarded.
- DATA:
  - req=0.
  - On data_ok=1: pulse the owner's *_data_ok for 1 cycle, then go to IDLE.
  - A new grant can occur in the cycle after return to IDLE. Back-to-back spacing is therefore a minimum of 1 idle cycle between transactions.
- Handshake forwarding:
  - The non-owner's addr_ok and data_ok are always 0.
  - inst_rdata and data_rdata both equal rdata combinationally; they are only meaningful with the matching *_data_ok.
- data_ok in IDLE (stale response after reset or abort) is ignored; nothing is forwarded.
- addr_ok in IDLE or DATA is ignored.
- Reset asserted in ADDR or DATA:
  - Next state is IDLE, and all outputs are 0 the next cycle.
  - A pending transaction is dropped without a *_data_ok.
- A requester that keeps req=1 after its data_ok is treated as a new request.
- Under continuous dual requests, grants alternate data, inst, data, inst, and so on.

Test Plan:
- Single instruction read:
  - Stimulus: inst_req=1, inst_addr=0xBFC00000; slave gives addr_ok at cycle 2, then data_ok with rdata=0x3C080001 at cycle 4.
  - Required: req=1 with addr=0xBFC00000, wr=0, size=2; inst_addr_ok pulses at cycle 2; inst_data_ok pulses at cycle 4 with inst_rdata=0x3C080001; data_* handshakes stay 0.
- Data byte write:
  - Stimulus: data_req=1, data_wr=1, data_size=0, data_addr=0x80001003, data_wdata=0x000000AB.
  - Required: bus shows wr=1, size=0, the same addr and wdata; data_addr_ok, then data_data_ok, follow the slave pulses.
- Simultaneous requests from reset with both held high for 4 transactions:
  - Required: grant order data, inst, data, inst.
  - Each transaction is separated by ≥1 IDLE cycle with req=0.
- addr_ok and data_ok in the same cycle (data read):
  - Required: data_addr_ok=data_data_ok=1 in that cycle; state IDLE in the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst in DATA, then the slave returns data_ok=1 two cycles after reset is released.
  - Required: all outputs 0 after the reset edge; the stale data_ok produces no *_data_ok.
- Abort:
  - Stimulus: owner drops inst_req in ADDR before addr_ok.
  - Required: req=0 next cycle; IDLE; no inst_addr_ok.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bus_arbiter
//  Brief    : Round-robin arbiter sharing one SRAM-like bus between the
//             instruction-fetch and data-access masters. Only one
//             transaction is outstanding at a time. Handshakes go back to
//             the master that owns the current transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction master
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // shared slave bus
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // owner / last_grant encoding: 0 = instruction master, 1 = data master
  localparam logic       c_OWNER_DATA = 1'b1;
  localparam logic [1:0] c_SIZE_WORD  = 2'd2;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;
  logic   r_last_grant;
  logic   w_last_grant_nxt;
  logic   w_own_req;
  logic   w_fwd_addr_ok;
  logic   w_fwd_data_ok;

  // The owner's live request line; dropping it before addr_ok aborts.
  assign w_own_req = (r_owner == c_OWNER_DATA) ? data_req : inst_req;

  // State, owner and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Grant decision and transaction sequencing.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (inst_req || data_req) begin
          // On contention, the master that did not win last time wins now.
          w_owner_nxt      = (inst_req && data_req) ? ~r_last_grant : data_req;
          w_last_grant_nxt = w_owner_nxt;
          w_state_nxt      = S_ADDR;
        end
      end
      S_ADDR: begin
        if (addr_ok) begin
          w_state_nxt = data_ok ? S_IDLE : S_DATA;
        end else if (!w_own_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (data_ok) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus drive from the owner's live fields and handshake steering.
  always_comb begin
    req           = 1'b0;
    wr            = 1'b0;
    size          = 2'd0;
    addr          = '0;
    wdata         = '0;
    w_fwd_addr_ok = 1'b0;
    w_fwd_data_ok = 1'b0;
    if (r_state == S_ADDR) begin
      req           = 1'b1;
      w_fwd_addr_ok = addr_ok;
      w_fwd_data_ok = addr_ok & data_ok;
      if (r_owner == c_OWNER_DATA) begin
        wr    = data_wr;
        size  = data_size;
        addr  = data_addr;
        wdata = data_wdata;
      end else begin
        size  = c_SIZE_WORD;
        addr  = inst_addr;
      end
    end else if (r_state == S_DATA) begin
      w_fwd_data_ok = data_ok;
    end
  end

  assign inst_addr_ok = w_fwd_addr_ok & (r_owner != c_OWNER_DATA);
  assign inst_data_ok = w_fwd_data_ok & (r_owner != c_OWNER_DATA);
  assign data_addr_ok = w_fwd_addr_ok & (r_owner == c_OWNER_DATA);
  assign data_data_ok = w_fwd_data_ok & (r_owner == c_OWNER_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_bus_arbiter
//  Brief    : Self-checking bench for sram_bus_arbiter, directed scenarios
//             followed by randomized traffic against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_addr_ok, inst_data_ok;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          req, wr, addr_ok, data_ok;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is a transaction open, has its address phase
  // been accepted, who owns it, and who won the last grant.
  bit m_busy, m_adone, m_owner, m_last;
  bit order_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, then compare against the model.
  task automatic settle();
    logic act, aok, dok;
    #1;
    act = m_busy && !m_adone;
    aok = act && addr_ok;
    dok = m_busy && data_ok && (m_adone || addr_ok);
    chk("req", req, act);
    chk("wr", wr, act && m_owner && data_wr);
    chk("size", size, !act ? 2'd0 : (m_owner ? data_size : 2'd2));
    chk("addr", addr, !act ? '0 : (m_owner ? data_addr : inst_addr));
    chk("wdata", wdata, (act && m_owner) ? data_wdata : '0);
    chk("inst_addr_ok", inst_addr_ok, aok && !m_owner);
    chk("inst_data_ok", inst_data_ok, dok && !m_owner);
    chk("data_addr_ok", data_addr_ok, aok && m_owner);
    chk("data_data_ok", data_data_ok, dok && m_owner);
    chk("inst_rdata", inst_rdata, rdata);
    chk("data_rdata", data_rdata, rdata);
  endtask

  // Advance one clock and apply the protocol rules to the model.
  task automatic tick();
    bit own;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_adone = 0; m_owner = 0; m_last = 0;
    end else if (!m_busy) begin
      if (inst_req || data_req) begin
        own = (inst_req && data_req) ? !m_last : data_req;
        m_owner = own; m_last = own; m_busy = 1; m_adone = 0;
      end
    end else if (!m_adone) begin
      if (addr_ok) begin
        if (data_ok) m_busy = 0; else m_adone = 1;
      end else if (!(m_owner ? data_req : inst_req)) begin
        m_busy = 0;
      end
    end else if (data_ok) begin
      m_busy = 0;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0; addr_ok = 0; data_ok = 0; rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    bit exp_order [4];
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    clear_inputs();
    rst = 1;
    @(negedge clk);
    do_reset();
    settle();
    chk("reset_req", req, 1'b0);
    chk("reset_addr", addr, 32'h0);
    tick();

    // Single instruction read
    inst_req = 1; inst_addr = 32'hBFC00000;
    step();                                   // cycle 0: IDLE
    settle();                                 // cycle 1: ADDR
    chk("ird_req", req, 1'b1);
    chk("ird_addr", addr, 32'hBFC00000);
    chk("ird_size", size, 2'd2);
    tick();
    addr_ok = 1;                              // cycle 2
    settle();
    chk("ird_aok", inst_addr_ok, 1'b1);
    chk("ird_daok", data_addr_ok, 1'b0);
    tick();
    addr_ok = 0; inst_req = 0;
    step();                                   // cycle 3: DATA
    data_ok = 1; rdata = 32'h3C080001;        // cycle 4
    settle();
    chk("ird_dok", inst_data_ok, 1'b1);
    chk("ird_rdata", inst_rdata, 32'h3C080001);
    chk("ird_ddok", data_data_ok, 1'b0);
    tick();
    data_ok = 0;
    step();

    // Data byte write
    data_req = 1; data_wr = 1; data_size = 2'd0;
    data_addr = 32'h80001003; data_wdata = 32'h000000AB;
    step();
    settle();
    chk("dwr_wr", wr, 1'b1);
    chk("dwr_size", size, 2'd0);
    chk("dwr_addr", addr, 32'h80001003);
    chk("dwr_wdata", wdata, 32'h000000AB);
    tick();
    addr_ok = 1;
    settle();
    chk("dwr_aok", data_addr_ok, 1'b1);
    tick();
    addr_ok = 0; data_req = 0;
    data_ok = 1;
    settle();
    chk("dwr_dok", data_data_ok, 1'b1);
    tick();
    data_ok = 0;
    step();

    // Dual requests from reset: grants must alternate data, inst, ...
    do_reset();
    inst_req = 1; inst_addr = 32'h00400000;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h10010000;
    order_q.delete();
    for (int i = 0; i < 60 && order_q.size() < 4; i++) begin
      addr_ok = m_busy && !m_adone;
      data_ok = m_busy && m_adone;
      settle();
      if (inst_addr_ok || data_addr_ok) order_q.push_back(data_addr_ok);
      tick();
    end
    chk("dual_count", order_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("dual_grant%0d", i), (i < order_q.size()) ? order_q[i] : 1'bx, exp_order[i]);
    inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 1;
    step();
    data_ok = 0;
    step();

    // addr_ok and data_ok together on a data read
    data_req = 1; data_wr = 0; data_addr = 32'h10010040;
    step();
    addr_ok = 1; data_ok = 1; rdata = 32'hCAFEF00D;
    settle();
    chk("same_aok", data_addr_ok, 1'b1);
    chk("same_dok", data_data_ok, 1'b1);
    chk("same_rdata", data_rdata, 32'hCAFEF00D);
    tick();
    addr_ok = 0; data_ok = 0; data_req = 0;
    settle();
    chk("same_idle_req", req, 1'b0);
    tick();

    // Reset while in DATA, stale data_ok afterwards
    inst_req = 1; inst_addr = 32'hBFC00010;
    step();
    addr_ok = 1;
    step();
    addr_ok = 0; inst_req = 0;
    rst = 1;
    step();
    rst = 0;
    settle();
    chk("rst_req", req, 1'b0);
    chk("rst_addr", addr, 32'h0);
    tick();
    step();
    data_ok = 1;
    settle();
    chk("stale_idok", inst_data_ok, 1'b0);
    chk("stale_ddok", data_data_ok, 1'b0);
    tick();
    data_ok = 0;

    // Abort: instruction master drops its request during ADDR
    inst_req = 1; inst_addr = 32'hBFC00020;
    step();
    inst_req = 0;
    settle();
    chk("abort_req_addr", req, 1'b1);
    chk("abort_aok", inst_addr_ok, 1'b0);
    tick();
    settle();
    chk("abort_req_next", req, 1'b0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      inst_req   = ($urandom_range(0, 3) != 0);
      data_req   = ($urandom_range(0, 2) != 0);
      inst_addr  = $urandom;
      data_wr    = $urandom_range(0, 1);
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = $urandom;
      data_wdata = $urandom;
      addr_ok    = $urandom_range(0, 1);
      data_ok    = ($urandom_range(0, 2) == 0);
      rdata      = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
